// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, baud divider helper and ASCII constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Truncating division: the bit period rounds down to whole clock cycles.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: bit_end marks the last cycle of each bit; the count restarts on clear.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Wrapping at LAST restarts the count exactly when the line moves to the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || !en || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_end = en && !clr && (count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-wide 8N1 UART transmitter with tx_start/tx_done handshake.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_tx
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_divider
    $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
  end

  uart_tx_state_t state, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic       bit_end;
  logic       line_next;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (state != IDLE),
    .clr    (state == IDLE),
    .bit_end(bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if ((state == IDLE) && tx_start) begin
      parity_bit <= ^tx_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      uart_tx   <= 1'b1;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_idx   <= bit_idx_next;
      uart_tx   <= line_next;
    end
  end

  // bit_idx counts data bits, then is reused to count stop bits.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx;
    tx_done      = 1'b0;
    line_next    = 1'b1;

    case (state)
      IDLE: begin
        if (tx_start) begin
          state_next   = START;
          shift_next   = tx_data;
          bit_idx_next = '0;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = shift_reg >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_idx == LAST_STOP) begin
            state_next   = IDLE;
            bit_idx_next = '0;
            tx_done      = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The line register follows the upcoming state, so it changes on the same edge as the FSM.
    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_next = parity_bit;
`endif
      default: line_next = 1'b1;
    endcase
  end

  assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: directed and random frames against a bit-list model.
module tb_uart_tx_serializer;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD      = 100_000;
  localparam int STOP_BITS = 1;
  localparam int CPB       = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       uart_tx;

  int checks;
  int failures;

  uart_tx_serializer #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Caller is positioned just after a rising edge; tx_start is sampled on the next edge.
  task automatic applyStimulus(input logic [7:0] b, input int busyRel, input int resetRel,
                               input bit pokeDone);
    logic exp_bits[$];
    int   frame_len;
    int   done_seen;
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(^b);
`endif
    for (int i = 0; i < STOP_BITS; i++) exp_bits.push_back(1'b1);
    frame_len = exp_bits.size() * CPB;
    done_seen = 0;

    tx_start = 1'b1;
    tx_data  = b;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    tx_data  = 8'($urandom);

    for (int rel = 0; rel < frame_len; rel++) begin
      @(negedge clk);
      checkOutput($sformatf("line b=%02h rel=%0d", b, rel), uart_tx, exp_bits[rel / CPB]);
      checkOutput($sformatf("busy b=%02h rel=%0d", b, rel), tx_busy, 1);
      checkOutput($sformatf("done b=%02h rel=%0d", b, rel), tx_done, (rel == frame_len - 1));
      if (tx_done) done_seen++;
      if (rel == busyRel) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end else if (rel == busyRel + 1) begin
        tx_start = 1'b0;
      end
      if (pokeDone && (rel == frame_len - 1)) tx_start = 1'b1;
      if (rel == resetRel) begin
        rst = 1'b1;
        #1;
        checkOutput("reset_line", uart_tx, 1);
        checkOutput("reset_busy", tx_busy, 0);
        checkOutput("reset_done", tx_done, 0);
        tx_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
    end

    @(posedge clk);
    #1;
    tx_start = 1'b0;
    checkOutput($sformatf("done_count b=%02h", b), done_seen, 1);
    checkOutput($sformatf("end_busy b=%02h", b), tx_busy, 0);
    checkOutput($sformatf("end_done b=%02h", b), tx_done, 0);
    checkOutput($sformatf("end_line b=%02h", b), uart_tx, 1);
    if (pokeDone) begin
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        checkOutput("poke_busy", tx_busy, 0);
        checkOutput("poke_line", uart_tx, 1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checkOutput("idle_line", uart_tx, 1);
      checkOutput("idle_busy", tx_busy, 0);
      checkOutput("idle_done", tx_done, 0);
    end
    @(posedge clk);
    #1;

    $display("[TB] single byte");
    applyStimulus(8'h35, -1, -1, 1'b0);

    $display("[TB] back-to-back");
    applyStimulus(8'h31, -1, -1, 1'b0);
    applyStimulus(uart_pkg::ASCII_SPACE, -1, -1, 1'b0);
    applyStimulus(uart_pkg::ASCII_LF, -1, -1, 1'b0);

    $display("[TB] busy ignore");
    applyStimulus(8'h00, 36, -1, 1'b0);

    $display("[TB] mid-frame reset");
    applyStimulus(8'h00, -1, 44, 1'b0);
    applyStimulus(8'h41, -1, -1, 1'b0);

    $display("[TB] start during done cycle");
    applyStimulus(8'hA5, -1, -1, 1'b1);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity");
    applyStimulus(8'h07, -1, -1, 1'b0);
    applyStimulus(8'h03, -1, -1, 1'b0);
`endif

    $display("[TB] random frames");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 80)) : -1,
                    -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
